// File: rtl/uart_pkg.sv
// Shared UART constants: divisor widths, oversampling ratio, default rates.
package uart_pkg;
  localparam int BAUD_INT_W           = 16;
  localparam int BAUD_FRAC_W          = 4;
  localparam int UART_OVERSAMPLE      = 16;
  localparam int CLK_FREQ_HZ          = 50_000_000;
  localparam int BAUD_DIV_INT_115200  = 27;
  localparam int BAUD_DIV_FRAC_115200 = 2;
endpackage

// File: rtl/frac_period_counter.sv
// Fractional-N period counter; emits one sample tick per divided period.
module frac_period_counter
  import uart_pkg::*;
#(
  parameter int INT_W    = BAUD_INT_W,
  parameter int FRAC_W   = BAUD_FRAC_W,
  parameter int DEF_INT  = BAUD_DIV_INT_115200,
  parameter int DEF_FRAC = BAUD_DIV_FRAC_115200
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              clr,
  input  logic              load,
  input  logic [INT_W-1:0]  ld_int,
  input  logic [FRAC_W-1:0] ld_frac,
  output logic              wrap,
  output logic              sample_tick
);

  logic [INT_W:0]    cnt;
  logic [INT_W:0]    plen;
  logic [INT_W:0]    cnt_nxt;
  logic [INT_W:0]    plen_nxt;
  logic [FRAC_W-1:0] frac_acc;
  logic [FRAC_W-1:0] active_frac;
  logic [INT_W-1:0]  active_int;
  logic [FRAC_W:0]   sum;
  logic              start;

  // cnt==0 marks the first enabled edge of a period
  always_comb begin
    start    = (cnt == '0);
    sum      = {1'b0, frac_acc} + {1'b0, active_frac};
    plen_nxt = plen;
    if (start)
      plen_nxt = {1'b0, active_int}
               + {{INT_W{1'b0}}, sum[FRAC_W]};
    cnt_nxt  = cnt + {{INT_W{1'b0}}, 1'b1};
    wrap     = en && !clr && (cnt_nxt == plen_nxt);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt         <= '0;
      plen        <= '0;
      frac_acc    <= '0;
      sample_tick <= 1'b0;
      active_int  <= INT_W'(DEF_INT);
      active_frac <= FRAC_W'(DEF_FRAC);
    end else begin
      if (load) begin
        active_int  <= ld_int;
        active_frac <= ld_frac;
      end
      if (clr) begin
        cnt         <= '0;
        frac_acc    <= '0;
        sample_tick <= 1'b0;
      end else if (en) begin
        if (start) begin
          frac_acc <= sum[FRAC_W-1:0];
          plen     <= plen_nxt;
        end
        cnt         <= wrap ? '0 : cnt_nxt;
        sample_tick <= wrap;
      end else begin
        sample_tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: sample, mid-bit and bit-rate ticks.
module baud_gen_frac
  import uart_pkg::*;
#(
  parameter int INT_W      = BAUD_INT_W,
  parameter int FRAC_W     = BAUD_FRAC_W,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DEF_INT    = BAUD_DIV_INT_115200,
  parameter int DEF_FRAC   = BAUD_DIV_FRAC_115200
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          en,
  input  logic [INT_W-1:0]              div_int,
  input  logic [FRAC_W-1:0]             div_frac,
  input  logic                          div_load,
  input  logic                          resync,
  output logic                          sample_tick,
  output logic                          mid_tick,
  output logic                          baud_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] bit_phase,
  output logic                          cfg_err
);

  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] MID_PH  = PH_W'(OVERSAMPLE/2 - 1);
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(OVERSAMPLE - 1);

  logic            ld_ok;
  logic            ld_bad;
  logic            wrap;
  logic [PH_W-1:0] os_cnt;

  assign ld_ok     = div_load && (div_int >= INT_W'(2));
  assign ld_bad    = div_load && (div_int <  INT_W'(2));
  assign bit_phase = os_cnt;

  frac_period_counter #(
    .INT_W    (INT_W),
    .FRAC_W   (FRAC_W),
    .DEF_INT  (DEF_INT),
    .DEF_FRAC (DEF_FRAC)
  ) u_period (
    .clk         (clk),
    .nrst        (nrst),
    .en          (en),
    .clr         (resync),
    .load        (ld_ok),
    .ld_int      (div_int),
    .ld_frac     (div_frac),
    .wrap        (wrap),
    .sample_tick (sample_tick)
  );

  // wrap already excludes resync and en=0, so the decodes need no gating
  always_ff @(posedge clk) begin
    if (!nrst) begin
      os_cnt    <= '0;
      mid_tick  <= 1'b0;
      baud_tick <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err   <= ld_bad;
      mid_tick  <= wrap && (os_cnt == MID_PH);
      baud_tick <= wrap && (os_cnt == LAST_PH);
      if (resync)
        os_cnt <= '0;
      else if (wrap)
        os_cnt <= (os_cnt == LAST_PH) ? '0 : os_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: directed vectors plus random model compare.
module tb_baud_gen_frac;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        div_load;
  logic        resync;

  logic       s16, m16, b16, e16;
  logic [3:0] ph16;
  logic       s4, m4, b4, e4;
  logic [1:0] ph4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  baud_gen_frac u16 (
    .clk(clk), .nrst(nrst), .en(en),
    .div_int(div_int), .div_frac(div_frac),
    .div_load(div_load), .resync(resync),
    .sample_tick(s16), .mid_tick(m16), .baud_tick(b16),
    .bit_phase(ph16), .cfg_err(e16)
  );

  baud_gen_frac #(.OVERSAMPLE(4)) u4 (
    .clk(clk), .nrst(nrst), .en(en),
    .div_int(div_int), .div_frac(div_frac),
    .div_load(div_load), .resync(resync),
    .sample_tick(s4), .mid_tick(m4), .baud_tick(b4),
    .bit_phase(ph4), .cfg_err(e4)
  );

  // Reference model of the OVERSAMPLE=16 instance: countdown of edges left
  int m_int, m_frac, m_acc, m_left, m_os;
  bit ms, mm, mb, me;

  task automatic model_edge();
    if (!nrst) begin
      m_int = 27; m_frac = 2; m_acc = 0;
      m_left = 0; m_os = 0;
      ms = 0; mm = 0; mb = 0; me = 0;
    end else begin
      me = div_load && (div_int < 2);
      ms = 0; mm = 0; mb = 0;
      if (resync) begin
        m_acc = 0; m_left = 0; m_os = 0;
      end else if (en) begin
        if (m_left == 0) begin
          m_acc  = m_acc + m_frac;
          m_left = m_int + ((m_acc >= 16) ? 1 : 0);
          m_acc  = m_acc % 16;
        end
        m_left = m_left - 1;
        if (m_left == 0) begin
          ms = 1;
          mm = (m_os == 7);
          mb = (m_os == 15);
          m_os = (m_os + 1) % 16;
        end
      end
      if (div_load && div_int >= 2) begin
        m_int = div_int; m_frac = div_frac;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!s16 && n < 2000);
  endtask

  task automatic load_resync(input int di, input int df);
    div_int = 16'(di); div_frac = 4'(df);
    div_load = 1; resync = 1;
    tick();
    div_load = 0; resync = 0;
  endtask

  typedef struct {
    int di;
    int df;
    int n;
    int clocks;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n, first_s, first_m, first_b, second_b, sc, bc, gaps28, last;
    bit saw_b;

    vecs[0] = '{4, 0, 8, 32};
    vecs[1] = '{4, 8, 32, 144};
    vecs[2] = '{5, 4, 16, 84};
    vecs[3] = '{2, 15, 16, 47};
    vecs[4] = '{27, 2, 16, 434};
    vecs[5] = '{3, 1, 16, 49};
    vecs[6] = '{7, 12, 4, 31};

    nrst = 0; en = 0; div_int = 0; div_frac = 0;
    div_load = 0; resync = 0;

    // reset and integer divide, OVERSAMPLE=4 instance
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_out", {s16, m16, b16, ph16, e16, s4, m4, b4, ph4, e4}, 32'h0);
    end
    nrst = 1; en = 1;
    load_resync(4, 0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("int_div_os4", {s4, m4, b4, ph4},
          {(k % 4 == 0), (k == 8), (k == 16), 2'((k / 4) % 4)});
    end

    // table of divisors: clocks from resync to the n-th sample tick
    foreach (vecs[v]) begin
      load_resync(vecs[v].di, vecs[v].df);
      sc = 0; n = 0;
      while (sc < vecs[v].n && n < 5000) begin
        tick();
        n++;
        if (s16) sc++;
      end
      chk("vec_clocks", n, vecs[v].clocks);
    end

    // enable gating
    load_resync(4, 0);
    for (int i = 0; i < 6; i++) tick();
    en = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("gap_hold", {s16, m16, b16, ph16}, {3'b000, 4'd1});
    end
    en = 1;
    wait_tick(n);
    chk("gap_resume", n, 2);
    chk("gap_phase", ph16, 2);

    // resync two clocks before a baud tick
    load_resync(4, 0);
    for (int i = 0; i < 61; i++) tick();
    chk("pre_resync_ph", ph16, 15);
    resync = 1;
    tick();
    resync = 0;
    chk("resync_clear", {s16, m16, b16, ph16}, 32'h0);
    first_s = 0; first_m = 0; saw_b = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (s16 && first_s == 0) first_s = k;
      if (m16 && first_m == 0) first_m = k;
      if (b16) saw_b = 1;
    end
    chk("resync_first_s", first_s, 4);
    chk("resync_first_mid", first_m, 32);
    chk("resync_no_baud", saw_b, 0);

    // rejected load
    load_resync(4, 0);
    tick();
    div_int = 1; div_load = 1;
    tick();
    div_load = 0;
    chk("cfg_err_hi", e16, 1);
    tick();
    chk("cfg_err_lo", e16, 0);
    wait_tick(n);
    chk("bad_ld_first", n, 1);
    wait_tick(n);
    chk("bad_ld_next", n, 4);

    // load mid-period
    load_resync(4, 0);
    tick();
    div_int = 6; div_load = 1;
    tick();
    div_load = 0;
    wait_tick(n);
    chk("mid_ld_old", n, 2);
    wait_tick(n);
    chk("mid_ld_new1", n, 6);
    wait_tick(n);
    chk("mid_ld_new2", n, 6);

    // random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      nrst     = ($urandom % 400) != 0;
      en       = ($urandom % 8) != 0;
      resync   = ($urandom % 64) == 0;
      div_load = ($urandom % 32) == 0;
      div_int  = 16'($urandom_range(0, 7));
      div_frac = 4'($urandom);
      tick();
      chk("rand", {s16, m16, b16, ph16, e16},
          {ms, mm, mb, 4'(m_os), me});
    end

    // default rate from reset over 200 us at 50 MHz
    nrst = 0; en = 1; resync = 0; div_load = 0;
    tick();
    nrst = 1;
    sc = 0; bc = 0; first_b = 0; second_b = 0;
    gaps28 = 0; last = 0;
    for (int e = 1; e <= 10000; e++) begin
      tick();
      if (s16) begin
        sc++;
        if (e - last == 28) gaps28++;
        last = e;
      end
      if (b16) begin
        bc++;
        if (bc == 1) first_b = e;
        if (bc == 2) second_b = e;
      end
    end
    chk("def_first_baud", first_b, 434);
    chk("def_second_baud", second_b, 868);
    chk("def_samples", sc, 368);
    chk("def_bauds", bc, 23);
    chk("def_long_periods", gaps28, 46);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
